// File: rtl/night_rider_seq.sv
// night_rider_seq -- bouncing LED scanner sequencer.
//
// Converts the slow toggling divider clock into single-cycle step events.
// Those steps move a lit LED back and forth across the bar. The LED holds
// at each end for DWELL steps before it reverses. slow_clk is only sampled
// as data; all state runs on clk_in.
//
// Optional build macro: TRAIL_EN
//   defined   : led also lights the position before the most recent step,
//               which gives a 2-LED comet tail. A single LED is lit during
//               a dwell.
//   undefined : led is strictly one-hot.
//
// Ports:
//   clk_in   in   system clock
//   rst      in   asynchronous reset, active-high
//   slow_clk in   toggling divider output (asynchronous, synchronized here)
//   start    in   1-cycle pulse, begins scanning from IDLE
//   stop     in   1-cycle pulse, returns to IDLE from any state (wins over start)
//   speed    in   step every 2^speed slow_clk rising edges
//   led      out  LED drive, bit pos lit (0 in IDLE)
//   pos      out  current LED index
//   dir      out  0 = moving up, 1 = moving down
//   running  out  high in every state except IDLE
//   o_state  out  FSM state, for debug/observation
//
// Handshake: start/stop are plain single-cycle strobes sampled on clk_in.
// There is no ready; start is ignored unless the FSM is in IDLE.
module night_rider_seq #(
  parameter int NUM_LEDS = 8,
  parameter int DWELL    = 2,
  parameter int POS_W    = 3
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic                slow_clk,
  input  logic                start,
  input  logic                stop,
  input  logic [1:0]          speed,
  output logic [NUM_LEDS-1:0] led,
  output logic [POS_W-1:0]    pos,
  output logic                dir,
  output logic                running,
  output logic [2:0]          o_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUN_UP   = 3'd1,
    DWELL_HI = 3'd2,
    RUN_DN   = 3'd3,
    DWELL_LO = 3'd4
  } state_t;

  localparam int DCNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int DWELL_LAST_I = (DWELL > 0) ? DWELL - 1 : 0;
  localparam logic [DCNT_W-1:0]   DWELL_LAST = DCNT_W'(DWELL_LAST_I);
  localparam logic [POS_W-1:0]    LAST_POS   = POS_W'(NUM_LEDS - 1);
  localparam logic [NUM_LEDS-1:0] LED0       = NUM_LEDS'(1);

  state_t              r_state;
  logic [POS_W-1:0]    r_pos;
  logic [NUM_LEDS-1:0] r_led;
  logic                r_dir;
  logic                r_running;
  logic [DCNT_W-1:0]   r_dcnt;

  // Synchronizer and edge detector for slow_clk.
  logic r_sync1, r_sync2, r_slow_q;
  logic w_tick;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_slow_q <= 1'b0;
    end else begin
      r_sync1  <= slow_clk;
      r_sync2  <= r_sync1;
      r_slow_q <= r_sync2;
    end
  end

  assign w_tick = r_sync2 & ~r_slow_q;

  // Prescaler. The rate is re-latched only at start and at each step.
  // This means a speed change never cuts an interval short.
  logic [2:0] r_pcnt;
  logic [1:0] r_spd;
  logic [2:0] w_pmax;
  logic       w_active;
  logic       w_step;

  assign w_pmax   = (3'd1 << r_spd) - 3'd1;
  assign w_active = (r_state != IDLE);
  assign w_step   = w_tick && w_active && !stop && (r_pcnt == w_pmax);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_pcnt <= 3'd0;
      r_spd  <= 2'd0;
    end else if (stop) begin
      r_pcnt <= 3'd0;
    end else if (start && !w_active) begin
      r_pcnt <= 3'd0;
      r_spd  <= speed;
    end else if (w_tick && w_active) begin
      if (r_pcnt == w_pmax) begin
        r_pcnt <= 3'd0;
        r_spd  <= speed;
      end else begin
        r_pcnt <= r_pcnt + 3'd1;
      end
    end
  end

  logic [POS_W-1:0] w_pos_up, w_pos_dn;
  assign w_pos_up = r_pos + 1'b1;
  assign w_pos_dn = r_pos - 1'b1;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pos     <= '0;
      r_led     <= '0;
      r_dir     <= 1'b0;
      r_running <= 1'b0;
      r_dcnt    <= '0;
    end else if (stop) begin
      r_state   <= IDLE;
      r_pos     <= '0;
      r_led     <= '0;
      r_dir     <= 1'b0;
      r_running <= 1'b0;
      r_dcnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state   <= RUN_UP;
            r_pos     <= '0;
            r_led     <= LED0;
            r_dir     <= 1'b0;
            r_running <= 1'b1;
            r_dcnt    <= '0;
          end
        end
        RUN_UP: begin
          if (w_step) begin
            r_pos <= w_pos_up;
            r_led <= LED0 << w_pos_up;
            if (w_pos_up == LAST_POS) begin
              if (DWELL > 0) begin
                r_state <= DWELL_HI;
              end else begin
                r_state <= RUN_DN;
                r_dir   <= 1'b1;
              end
            end
          end
        end
        DWELL_HI: begin
          if (w_step) begin
            if (r_dcnt == DWELL_LAST) begin
              r_state <= RUN_DN;
              r_dir   <= 1'b1;
              r_dcnt  <= '0;
            end else begin
              r_dcnt <= r_dcnt + 1'b1;
            end
          end
        end
        RUN_DN: begin
          if (w_step) begin
            r_pos <= w_pos_dn;
            r_led <= LED0 << w_pos_dn;
            if (w_pos_dn == '0) begin
              if (DWELL > 0) begin
                r_state <= DWELL_LO;
              end else begin
                r_state <= RUN_UP;
                r_dir   <= 1'b0;
              end
            end
          end
        end
        DWELL_LO: begin
          if (w_step) begin
            if (r_dcnt == DWELL_LAST) begin
              r_state <= RUN_UP;
              r_dir   <= 1'b0;
              r_dcnt  <= '0;
            end else begin
              r_dcnt <= r_dcnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef TRAIL_EN
  // Tail = previous position as a one-hot mask. It is held at zero whenever
  // the previous position equals the current one (after start, during a
  // dwell), so only the head is lit then.
  logic [NUM_LEDS-1:0] r_prev_led;
  logic                w_run_step;
  logic                w_lands_end;

  assign w_run_step  = w_step && ((r_state == RUN_UP) || (r_state == RUN_DN));
  assign w_lands_end = (r_state == RUN_UP) ? (w_pos_up == LAST_POS)
                                           : (w_pos_dn == '0);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_prev_led <= '0;
    end else if (stop || (start && !w_active)) begin
      r_prev_led <= '0;
    end else if (w_run_step) begin
      r_prev_led <= (w_lands_end && (DWELL > 0)) ? '0 : r_led;
    end else if (w_step) begin
      r_prev_led <= '0;
    end
  end

  assign led = r_led | r_prev_led;
`else
  assign led = r_led;
`endif

  assign pos     = r_pos;
  assign dir     = r_dir;
  assign running = r_running;
  assign o_state = r_state;

endmodule

// File: tb/tb_night_rider_seq.sv
// Directed bench for night_rider_seq (default build, TRAIL_EN undefined).
// The main instance uses NUM_LEDS=8 and DWELL=2. A second instance with
// DWELL=0 shares all inputs so the immediate reversal at the top can be seen.
module tb_night_rider_seq;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       slow_clk = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [1:0] speed = 2'd0;

  logic [7:0] led, led_z;
  logic [2:0] pos, pos_z;
  logic       dir, dir_z, running, running_z;
  logic [2:0] st, st_z;

  int n_cmp = 0;
  int n_fail = 0;

  night_rider_seq #(.NUM_LEDS(8), .DWELL(2), .POS_W(3)) dut (
    .clk_in(clk_in), .rst(rst), .slow_clk(slow_clk), .start(start),
    .stop(stop), .speed(speed), .led(led), .pos(pos), .dir(dir),
    .running(running), .o_state(st)
  );

  night_rider_seq #(.NUM_LEDS(8), .DWELL(0), .POS_W(3)) dut_z (
    .clk_in(clk_in), .rst(rst), .slow_clk(slow_clk), .start(start),
    .stop(stop), .speed(speed), .led(led_z), .pos(pos_z), .dir(dir_z),
    .running(running_z), .o_state(st_z)
  );

  // Clock
  always #5 clk_in = ~clk_in;

  // Driver tasks: inputs change on the falling edge only.
  task automatic tick();
    @(negedge clk_in) slow_clk = 1'b1;
    repeat (3) @(negedge clk_in);
    slow_clk = 1'b0;
    repeat (3) @(negedge clk_in);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_start();
    @(negedge clk_in) start = 1'b1;
    @(negedge clk_in) start = 1'b0;
  endtask

  task automatic do_stop();
    @(negedge clk_in) stop = 1'b1;
    @(negedge clk_in) stop = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk_in);
    n_cmp++; if (led !== 8'h00) begin n_fail++; $display("FAIL reset_led got %h want 00", led); end
    n_cmp++; if (pos !== 3'd0) begin n_fail++; $display("FAIL reset_pos got %0d want 0", pos); end
    n_cmp++; if (dir !== 1'b0) begin n_fail++; $display("FAIL reset_dir got %b want 0", dir); end
    n_cmp++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running got %b want 0", running); end
    n_cmp++; if (st !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", st); end
    @(negedge clk_in) rst = 1'b0;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic test_rate();
    int exp_p[18] = '{2,3,4,5,6,7,7,7,6,5,4,3,2,1,0,0,0,1};
    logic exp_d[18] = '{0,0,0,0,0,0,0,1,1,1,1,1,1,1,1,1,0,0};
    logic [7:0] one;
    speed = 2'd0;
    do_start();
    n_cmp++; if (running !== 1'b1) begin n_fail++; $display("FAIL start_running got %b want 1", running); end
    n_cmp++; if (led !== 8'h01) begin n_fail++; $display("FAIL start_led got %h want 01", led); end
    n_cmp++; if (pos !== 3'd0 || dir !== 1'b0) begin n_fail++; $display("FAIL start_pos_dir got %0d/%b want 0/0", pos, dir); end
    // First tick: pos must move on the third clk_in edge after the rise.
    @(negedge clk_in) slow_clk = 1'b1;
    repeat (2) @(negedge clk_in);
    n_cmp++; if (pos !== 3'd0) begin n_fail++; $display("FAIL tick_early got %0d want 0", pos); end
    @(negedge clk_in);
    n_cmp++; if (pos !== 3'd1) begin n_fail++; $display("FAIL tick_latency got %0d want 1", pos); end
    slow_clk = 1'b0;
    repeat (3) @(negedge clk_in);
    for (int k = 0; k < 18; k++) begin
      tick();
      one = 8'h01 << exp_p[k];
      n_cmp++; if (pos !== 3'(exp_p[k])) begin n_fail++; $display("FAIL rate_pos tick %0d got %0d want %0d", k + 2, pos, exp_p[k]); end
      n_cmp++; if (dir !== exp_d[k]) begin n_fail++; $display("FAIL rate_dir tick %0d got %b want %b", k + 2, dir, exp_d[k]); end
      n_cmp++; if (led !== one) begin n_fail++; $display("FAIL rate_led tick %0d got %h want %h", k + 2, led, one); end
      if (k == 6) begin
        n_cmp++; if (st !== 3'd2) begin n_fail++; $display("FAIL dwell_state got %0d want 2", st); end
      end
      // DWELL=0 instance: tick 7 lands on 7 already reversed, tick 8 -> 6.
      if (k == 5) begin
        n_cmp++; if (pos_z !== 3'd7 || dir_z !== 1'b1) begin n_fail++; $display("FAIL nodwell_top got %0d/%b want 7/1", pos_z, dir_z); end
      end
      if (k == 6) begin
        n_cmp++; if (pos_z !== 3'd6 || dir_z !== 1'b1) begin n_fail++; $display("FAIL nodwell_next got %0d/%b want 6/1", pos_z, dir_z); end
      end
    end
    do_stop();
  endtask

  task automatic test_stop();
    speed = 2'd0;
    do_start();
    ticks(4);
    n_cmp++; if (pos !== 3'd4 || dir !== 1'b0) begin n_fail++; $display("FAIL pre_stop got %0d/%b want 4/0", pos, dir); end
    do_stop();
    n_cmp++; if (st !== 3'd0 || running !== 1'b0) begin n_fail++; $display("FAIL stop_state got %0d/%b want 0/0", st, running); end
    n_cmp++; if (led !== 8'h00 || pos !== 3'd0) begin n_fail++; $display("FAIL stop_outputs got %h/%0d want 00/0", led, pos); end
    @(negedge clk_in) begin start = 1'b1; stop = 1'b1; end
    @(negedge clk_in) begin start = 1'b0; stop = 1'b0; end
    n_cmp++; if (running !== 1'b0 || st !== 3'd0) begin n_fail++; $display("FAIL start_stop_same got %b/%0d want 0/0", running, st); end
    tick();
    n_cmp++; if (pos !== 3'd0 || led !== 8'h00) begin n_fail++; $display("FAIL idle_tick got %0d/%h want 0/00", pos, led); end
  endtask

  task automatic test_speed();
    speed = 2'd2;
    do_start();
    ticks(3);
    n_cmp++; if (pos !== 3'd0) begin n_fail++; $display("FAIL speed2_hold got %0d want 0", pos); end
    tick();
    n_cmp++; if (pos !== 3'd1) begin n_fail++; $display("FAIL speed2_step got %0d want 1", pos); end
    ticks(2);
    speed = 2'd0;
    tick();
    n_cmp++; if (pos !== 3'd1) begin n_fail++; $display("FAIL speed_change_mid got %0d want 1", pos); end
    tick();
    n_cmp++; if (pos !== 3'd2) begin n_fail++; $display("FAIL speed_change_done got %0d want 2", pos); end
    tick();
    n_cmp++; if (pos !== 3'd3) begin n_fail++; $display("FAIL speed0_step got %0d want 3", pos); end
    do_stop();
  endtask

  task automatic test_redundant_start();
    speed = 2'd1;
    do_start();
    ticks(6);
    n_cmp++; if (pos !== 3'd3) begin n_fail++; $display("FAIL speed1_pos got %0d want 3", pos); end
    tick();
    do_start();
    n_cmp++; if (pos !== 3'd3 || dir !== 1'b0 || running !== 1'b1) begin n_fail++; $display("FAIL restart_ignored got %0d/%b/%b want 3/0/1", pos, dir, running); end
    tick();
    n_cmp++; if (pos !== 3'd4) begin n_fail++; $display("FAIL restart_pcnt got %0d want 4", pos); end
    // Stuck high: one rising edge only, then nothing.
    @(negedge clk_in) slow_clk = 1'b1;
    repeat (40) @(negedge clk_in);
    n_cmp++; if (pos !== 3'd4) begin n_fail++; $display("FAIL stuck_high got %0d want 4", pos); end
    slow_clk = 1'b0;
    repeat (40) @(negedge clk_in);
    n_cmp++; if (pos !== 3'd4 || st !== 3'd1) begin n_fail++; $display("FAIL stuck_low got %0d/%0d want 4/1", pos, st); end
    tick();
    n_cmp++; if (pos !== 3'd5) begin n_fail++; $display("FAIL after_stuck got %0d want 5", pos); end
  endtask

  task automatic test_async_reset();
    @(negedge clk_in);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (led !== 8'h00 || pos !== 3'd0) begin n_fail++; $display("FAIL async_rst_out got %h/%0d want 00/0", led, pos); end
    n_cmp++; if (running !== 1'b0 || dir !== 1'b0) begin n_fail++; $display("FAIL async_rst_flags got %b/%b want 0/0", running, dir); end
    @(negedge clk_in) rst = 1'b0;
    tick();
    n_cmp++; if (running !== 1'b0 || pos !== 3'd0) begin n_fail++; $display("FAIL post_rst_idle got %b/%0d want 0/0", running, pos); end
  endtask

  initial begin
    test_reset();
    test_rate();
    test_stop();
    test_speed();
    test_redundant_start();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/night_rider_seq.md
Name: night_rider_seq

Overview:
- Sequencer for the LED scanner. Consumes the slow toggling clock produced by the 100K divider stage as a rate source.
- Converts that clock into step events and drives a one-hot "bouncing" LED position with a programmable step rate and a dwell time at each end.
- Sits between the divider chain and the LED pins. All logic runs on the system clock; the slow clock is never used as a clock.

Parameters:
- NUM_LEDS, 8, number of LEDs scanned; legal range 2..32.
- DWELL, 2, number of steps held at each end before reversing; 0 means reverse immediately.
- POS_W, 3, width of pos; must be at least clog2(NUM_LEDS).

Ports:
- clk_in  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- slow_clk  input  1  toggling divider output, asynchronous to the logic that samples it.
- start  input  1  single-cycle pulse; begins scanning from IDLE.
- stop  input  1  single-cycle pulse; returns to IDLE from any state.
- speed  input  2  step every 2^speed slow_clk rising edges (1, 2, 4 or 8).
- led  output  NUM_LEDS  one-hot LED drive; bit pos is lit.
- pos  output  POS_W  current LED index.
- dir  output  1  0 = moving up (increasing index), 1 = moving down.
- running  output  1  high in every state except IDLE.

Behaviour:
- Reset (async, rst=1):
  - State IDLE; led=0, pos=0, dir=0, running=0.
  - Synchronizer flops, edge register, prescale counter and dwell counter all cleared.
- Tick generation:
  - slow_clk passes through a 2-flop synchronizer, then a rising-edge detector.
  - tick is a 1-cycle pulse, 3 clk_in cycles after the slow_clk rising edge.
- Prescaler:
  - pcnt counts ticks only while running.
  - On a tick with pcnt == (1<<spd_q)-1, assert step for one cycle and clear pcnt.
  - spd_q is speed latched on start and on every step. A speed change therefore takes effect at the next step boundary, never mid-interval.
  - pcnt clears on start and on stop.
- FSM states: IDLE, RUN_UP, DWELL_HI, RUN_DN, DWELL_LO.
  - IDLE, start=1: go to RUN_UP; pos=0, led=1, dir=0, running=1. Output registers update on the cycle after start.
  - RUN_UP, step: pos <= pos+1.
    - If the new pos == NUM_LEDS-1: go to DWELL_HI when DWELL>0, else go to RUN_DN with dir=1.
  - DWELL_HI, step: dcnt increments.
    - When dcnt == DWELL-1: go to RUN_DN, dir=1, dcnt=0.
    - pos stays at NUM_LEDS-1 throughout.
  - RUN_DN, step: pos <= pos-1.
    - If the new pos == 0: go to DWELL_LO when DWELL>0, else go to RUN_UP with dir=0.
  - DWELL_LO: mirror of DWELL_HI; exits to RUN_UP with dir=0.
- led equals 1<<pos in all non-IDLE states and 0 in IDLE. Registered: updates the same cycle pos updates.
- Boundaries and conflicts:
  - stop, any state: next cycle IDLE, led=0, pos=0, dir=0, running=0; dcnt and pcnt cleared.
  - start and stop in the same cycle: stop wins.
  - start while running: ignored; no restart.
  - tick coinciding with stop: discarded.
  - pos never leaves 0..NUM_LEDS-1; no wrap-around.
  - Full round trip, in steps: 2*(NUM_LEDS-1) + 2*DWELL.
  - slow_clk stuck high or low: no ticks; the FSM holds its state indefinitely.
  - rst asserted mid-scan: outputs clear immediately (asynchronously). After release, the block waits in IDLE for start.

Optional Feature:
- Macro TRAIL_EN.
  - Defined: led = (1<<pos) | (1<<prev_pos).
    - prev_pos is the position before the most recent step, giving a 2-LED comet tail.
    - During a dwell, prev_pos collapses to pos, so a single LED is lit.
    - prev_pos clears with start, stop and rst. Immediately after start, only bit 0 is lit.
  - Undefined: strictly one-hot led; no prev_pos register.

Test Plan:
- Reset: assert rst mid-scan at pos=5 -> led=0, pos=0, running=0 in the same cycle, before any clk_in edge.
- Rate: NUM_LEDS=8, DWELL=2, speed=0, start -> pos sequence 0..7, held at 7 for 2 ticks, 6..0, held at 0 for 2 ticks, then 1. Each step occurs 3 cycles after a slow_clk rising edge. Round trip = 18 ticks.
- Speed: speed=2 -> exactly 4 slow_clk rising edges per pos change. Change speed to 0 mid-interval -> the current 4-tick interval completes, then 1 tick per step.
- Stop: stop at pos=4, dir=0 -> next cycle IDLE, led=0. start and stop in the same cycle while IDLE -> stays in IDLE.
- Redundant start: start pulses at pos=3 while running -> no effect on pos, dir or pcnt.
- TRAIL_EN build: steps 2->3 -> led=8'b0000_1100. At the top dwell -> led=8'b1000_0000. DWELL=0 build -> 7 followed directly by 6 with dir=1.
